// File: rtl/alu_mul_sequencer.sv
// Purpose : shift-and-add unsigned multiplier, low len bits of a*b, driving one shared combinational ALU.
// Latency : start accepted at edge k -> done pulse (product valid) in cycle k+3*len+1; one op per 3*len+2 cycles.
// Backpr. : none; start is only sampled in IDLE, requests seen while busy (including DONE) are dropped, not queued.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start, a, b       request and operands (captured on acceptance)
//   busy, done        busy from the cycle after acceptance through DONE; done is a one-cycle pulse
//   product           registered (a*b) mod 2^len, held until the next result
//   alu_s0, alu_s1    replicated ALU select bits ({s0,s1}: 00 add, 10 shr, 11 shl)
//   alu_a, alu_b      ALU operands
//   alu_s             ALU result, captured at the end of the same cycle
module alu_mul_sequencer #(
  parameter int len = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [len-1:0] a,
  input  logic [len-1:0] b,
  output logic           busy,
  output logic           done,
  output logic [len-1:0] product,
  output logic [len-1:0] alu_s0,
  output logic [len-1:0] alu_s1,
  output logic [len-1:0] alu_a,
  output logic [len-1:0] alu_b,
  input  logic [len-1:0] alu_s
);

  localparam int cw = (len > 2) ? $clog2(len) : 1;
  localparam logic [cw-1:0] cnt_last = cw'(len - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADD  = 3'd1,
    SHL  = 3'd2,
    SHR  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [len-1:0] acc;
  logic [len-1:0] acc_next;
  logic [len-1:0] mcand;
  logic [len-1:0] mcand_next;
  logic [len-1:0] mplier;
  logic [len-1:0] mplier_next;
  logic [len-1:0] product_q;
  logic [len-1:0] product_next;
  logic [cw-1:0]  cnt;
  logic [cw-1:0]  cnt_next;
  logic           sel0;
  logic           sel1;

  // State and datapath registers. Reset wins over every transition, so an
  // in-flight operation is simply abandoned and no done pulse follows.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      product_q <= '0;
    end else begin
      state     <= state_next;
      acc       <= acc_next;
      mcand     <= mcand_next;
      mplier    <= mplier_next;
      cnt       <= cnt_next;
      product_q <= product_next;
    end
  end

  // Next-state and ALU decode. Each iteration is three ALU passes:
  // conditional accumulate, multiplicand shift left, multiplier shift right.
  always_comb begin
    state_next   = state;
    acc_next     = acc;
    mcand_next   = mcand;
    mplier_next  = mplier;
    cnt_next     = cnt;
    product_next = product_q;
    sel0         = 1'b0;
    sel1         = 1'b0;
    alu_a        = '0;
    alu_b        = '0;

    case (state)
      IDLE: begin
        if (start) begin
          acc_next    = '0;
          mcand_next  = a;
          mplier_next = b;
          cnt_next    = '0;
          state_next  = ADD;
        end
      end

      ADD: begin
        // Adding zero when the multiplier LSB is clear keeps the cycle count
        // data-independent; the carry out is dropped by the ALU width.
        alu_a      = acc;
        alu_b      = mplier[0] ? mcand : '0;
        acc_next   = alu_s;
        state_next = SHL;
      end

      SHL: begin
        sel0       = 1'b1;
        sel1       = 1'b1;
        alu_a      = mcand;
        mcand_next = alu_s;
        state_next = SHR;
      end

      SHR: begin
        sel0        = 1'b1;
        alu_a       = mplier;
        mplier_next = alu_s;
        // No early exit on a zero multiplier: always len iterations.
        if (cnt == cnt_last) begin
          product_next = acc;
          state_next   = DONE;
        end else begin
          cnt_next   = cnt + cw'(1);
          state_next = ADD;
        end
      end

      DONE: begin
        // start is deliberately not looked at here.
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign alu_s0  = {len{sel0}};
  assign alu_s1  = {len{sel1}};
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
module tb_alu_mul_sequencer;

  localparam int len = 4;

  logic           clk;
  logic           rst;
  logic           start;
  logic [len-1:0] a_i;
  logic [len-1:0] b_i;
  logic           busy;
  logic           done;
  logic [len-1:0] product;
  logic [len-1:0] alu_s0;
  logic [len-1:0] alu_s1;
  logic [len-1:0] alu_a;
  logic [len-1:0] alu_b;
  logic [len-1:0] alu_s;

  alu_mul_sequencer #(.len(len)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a_i),
    .b       (b_i),
    .busy    (busy),
    .done    (done),
    .product (product),
    .alu_s0  (alu_s0),
    .alu_s1  (alu_s1),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_s   (alu_s)
  );

  // Combinational reference ALU, {s0,s1}: 00 add, 01 sub, 10 shr, 11 shl.
  always_comb begin
    case ({alu_s0[0], alu_s1[0]})
      2'b00:   alu_s = alu_a + alu_b;
      2'b01:   alu_s = alu_a - alu_b;
      2'b10:   alu_s = alu_a >> 1;
      default: alu_s = alu_a << 1;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int prod;
    int acc_edge;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   busy_run = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (busy === 1'b1) busy_run++;
    else busy_run = 0;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("product", int'(product), e.prod);
        chk("latency", cyc - e.acc_edge + 1, 3 * len + 1);
        chk("busy_len", busy_run, 3 * len + 1);
      end
    end
  end

  // Drive a one-cycle start from a negedge; returns at the next negedge,
  // where cyc equals the acceptance edge count.
  task automatic issue(input int av, input int bv, input int prod);
    exp_t e;
    a_i   = len'(av);
    b_i   = len'(bv);
    start = 1'b1;
    e.prod     = prod;
    e.acc_edge = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic to_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk(name, exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic chk_alu_zero(input string name);
    chk({name, "_s0"}, int'(alu_s0), 0);
    chk({name, "_s1"}, int'(alu_s1), 0);
    chk({name, "_a"},  int'(alu_a),  0);
    chk({name, "_b"},  int'(alu_b),  0);
  endtask

  // Hand-derived ALU trace for a=3, b=5: {s0, s1, alu_a, alu_b} per busy cycle.
  int tr_s0 [12] = '{0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1};
  int tr_s1 [12] = '{0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0};
  int tr_a  [12] = '{0, 3, 5, 3, 6, 2, 3, 12, 1, 15, 8, 0};
  int tr_b  [12] = '{3, 0, 0, 0, 0, 0, 12, 0, 0, 0, 0, 0};

  initial begin
    int acc_edge;
    rst   = 1'b1;
    start = 1'b0;
    a_i   = '0;
    b_i   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_product", int'(product), 0);
    chk_alu_zero("rst_alu");

    // 3*5 with per-cycle ALU trace
    issue(3, 5, 15);
    acc_edge = cyc;
    for (int i = 0; i < 12; i++) begin
      to_cyc(acc_edge + i);
      chk($sformatf("trace%0d_s0", i), int'(alu_s0), tr_s0[i] != 0 ? 15 : 0);
      chk($sformatf("trace%0d_s1", i), int'(alu_s1), tr_s1[i] != 0 ? 15 : 0);
      chk($sformatf("trace%0d_a", i),  int'(alu_a),  tr_a[i]);
      chk($sformatf("trace%0d_b", i),  int'(alu_b),  tr_b[i]);
    end
    to_cyc(acc_edge + 12);
    chk_alu_zero("done_alu");
    drain("timeout_3x5");
    @(negedge clk);
    chk_alu_zero("idle_alu");

    // Overflow truncation
    issue(7, 6, 10);
    drain("timeout_7x6");
    issue(15, 15, 1);
    drain("timeout_15x15");

    // Zero operands, no early exit
    issue(0, 9, 0);
    drain("timeout_0x9");
    issue(9, 0, 0);
    drain("timeout_9x0");

    // start raised only during DONE must be dropped
    issue(2, 5, 10);
    acc_edge = cyc;
    to_cyc(acc_edge + 12);
    a_i   = 4'd7;
    b_i   = 4'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_start_ignored", int'(busy), 0);
    @(negedge clk);
    chk("done_start_ignored2", int'(busy), 0);
    repeat (20) @(negedge clk);
    drain("timeout_2x5");

    // start held high: one 3*3 every 14 cycles, operand noise while busy
    a_i   = 4'd3;
    b_i   = 4'd3;
    start = 1'b1;
    acc_edge = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      e.prod     = 9;
      e.acc_edge = acc_edge + 14 * i;
      exp_q.push_back(e);
    end
    for (int i = 0; i < 3; i++) begin
      to_cyc(acc_edge + 14 * i + 1);
      a_i = 4'd15;
      b_i = 4'd15;
      if (i == 2) start = 1'b0;
      to_cyc(acc_edge + 14 * i + 10);
      a_i = 4'd3;
      b_i = 4'd3;
    end
    drain("timeout_held");
    repeat (3) @(negedge clk);

    // Reset in the 6th busy cycle aborts the operation
    issue(5, 3, 15);
    acc_edge = cyc;
    to_cyc(acc_edge + 5);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_product", int'(product), 0);
    chk_alu_zero("abort_alu");
    rst = 1'b0;
    repeat (20) @(negedge clk);
    issue(2, 3, 6);
    drain("timeout_2x3");

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
